// File: rtl/seg_anim_pkg.sv
// seg_anim_pkg: shared modes, state encoding, frame counts and segment bit positions
package seg_anim_pkg;
    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_HOLD = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam int NUM_ANIM = 6;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    typedef enum logic [1:0] {ST_AUTO, ST_HOLD, ST_STEP} seq_state_t;
    function automatic logic [3:0] n_frames(input logic [2:0] anim);
        return anim == 3'd0 ? 4'd10 : anim <= 3'd3 ? 4'd7 : 4'd6;
    endfunction
endpackage

// File: rtl/seg_anim_rom.sv
// seg_anim_rom: pattern tables for all animations; unused table slots read as blank
module seg_anim_rom
    import seg_anim_pkg::*;
(
    input  logic [2:0] anim,
    input  logic [3:0] frame,
    output logic [6:0] segments
);
    localparam logic [6:0] SA = 7'(1 << SEG_A);
    localparam logic [6:0] SB = 7'(1 << SEG_B);
    localparam logic [6:0] SC = 7'(1 << SEG_C);
    localparam logic [6:0] SD = 7'(1 << SEG_D);
    localparam logic [6:0] SE = 7'(1 << SEG_E);
    localparam logic [6:0] SF = 7'(1 << SEG_F);
    localparam logic [6:0] SG = 7'(1 << SEG_G);
    localparam logic [6:0] A0 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [6:0] A1 [16] = '{SA, SB, SC, SD, SE, SF, SG, 7'h00,
                                       7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [6:0] A2 [16] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h00,
                                       7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [6:0] A3 [16] = '{7'h7F, 7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60, 7'h40, 7'h00,
                                       7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [6:0] A4 [16] = '{SA, SB, SG, SE, SD, SC, 7'h00, 7'h00,
                                       7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [6:0] A5 [16] = '{7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h00,
                                       7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    always_comb begin
        segments = anim == 3'd0 ? A0[frame] :
                   anim == 3'd1 ? A1[frame] :
                   anim == 3'd2 ? A2[frame] :
                   anim == 3'd3 ? A3[frame] :
                   anim == 3'd4 ? A4[frame] :
                   anim == 3'd5 ? A5[frame] : 7'h00;
    end
endmodule

// File: rtl/seg_anim_sequencer.sv
// seg_anim_sequencer: multi-digit seven-segment animation sequencer with auto, hold and step modes
module seg_anim_sequencer
    import seg_anim_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_WIDTH   = 24,
    parameter int DEFAULT_DIV = 10_000_000,
    parameter int SCAN_DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            div_sel,
    input  logic [1:0]            mode,
    input  logic [2:0]            anim_sel,
    input  logic                  step,
    input  logic                  pause,
    input  logic                  phase_en,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [2:0]            anim_id,
    output logic [3:0]            frame,
    output logic                  tick,
    output logic                  seq_done
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    seq_state_t state, state_d;
    logic [DIV_WIDTH-1:0] div_cnt, cmp;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;
    logic [2:0] anim_d, eff_sel;
    logic [3:0] frame_d, n_cur, pf;
    logic [4:0] psum;
    logic [6:0] rom_seg;
    logic done_d, adv, last, scan_wrap;
    assign cmp = div_sel == 8'd0 ? DIV_WIDTH'(DEFAULT_DIV) : DIV_WIDTH'({div_sel, 10'b0});
    assign eff_sel = anim_sel >= 3'(NUM_ANIM) ? 3'd0 : anim_sel;
    assign n_cur = n_frames(anim_id);
    assign last = frame >= n_cur - 4'd1;
    assign adv = !pause && (state == ST_STEP ? step : tick);
    assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
    // Digits further along the scan run ahead by their index, folded back into range once
    assign psum = {1'b0, frame} + 5'(scan_idx);
    assign pf = !phase_en ? frame : psum >= {1'b0, n_cur} ? 4'(psum - {1'b0, n_cur}) : psum[3:0];
    seg_anim_rom u_rom (
        .anim     (anim_id),
        .frame    (pf),
        .segments (rom_seg)
    );
    always_comb begin
        state_d = mode == MODE_AUTO ? ST_AUTO : mode == MODE_STEP ? ST_STEP : ST_HOLD;
        anim_d = anim_id;
        frame_d = frame;
        done_d = 1'b0;
        if (state == ST_HOLD && eff_sel != anim_id) begin
            anim_d = eff_sel;
            frame_d = 4'd0;
        end else if (adv) begin
            frame_d = last ? 4'd0 : frame + 4'd1;
            if (last && state != ST_HOLD) begin
                anim_d = anim_id == 3'(NUM_ANIM - 1) ? 3'd0 : anim_id + 3'd1;
                done_d = anim_id == 3'(NUM_ANIM - 1);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_AUTO;
            div_cnt <= '0;
            tick <= 1'b0;
            anim_id <= 3'd0;
            frame <= 4'd0;
            seq_done <= 1'b0;
            scan_cnt <= '0;
            scan_idx <= '0;
            seg_out <= 7'h00;
            digit_en <= '0;
        end else begin
            state <= state_d;
            anim_id <= anim_d;
            frame <= frame_d;
            seq_done <= done_d;
            tick <= !pause && div_cnt >= cmp;
            if (!pause)
                div_cnt <= div_cnt >= cmp ? '0 : div_cnt + DIV_WIDTH'(1);
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
            if (scan_wrap)
                scan_idx <= scan_idx == IW'(NUM_DIGITS - 1) ? '0 : scan_idx + IW'(1);
            seg_out <= rom_seg;
            digit_en <= NUM_DIGITS'(1) << scan_idx;
        end
    end
endmodule

// File: tb/tb_seg_anim_sequencer.sv
// tb_seg_anim_sequencer: directed checks of sequencing, hold/step modes, phased scan and async reset
module tb_seg_anim_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int total = 0, bad = 0, dcnt = 0;

    logic a_rst = 1'b1, a_step = 1'b0, a_pause = 1'b0, a_ph = 1'b0;
    logic [7:0] a_div = 8'd0;
    logic [1:0] a_mode = 2'b00;
    logic [2:0] a_sel = 3'd0;
    logic [6:0] a_seg;
    logic [0:0] a_dig;
    logic [2:0] a_anim;
    logic [3:0] a_frame;
    logic a_tick, a_done;

    logic b_rst = 1'b1, b_step = 1'b0, b_pause = 1'b0, b_ph = 1'b1;
    logic [7:0] b_div = 8'd0;
    logic [1:0] b_mode = 2'b10;
    logic [2:0] b_sel = 3'd0;
    logic [6:0] b_seg;
    logic [3:0] b_dig;
    logic [2:0] b_anim;
    logic [3:0] b_frame;
    logic b_tick, b_done;

    logic c_rst = 1'b1, c_step = 1'b0, c_pause = 1'b0, c_ph = 1'b0;
    logic [7:0] c_div = 8'd0;
    logic [1:0] c_mode = 2'b00;
    logic [2:0] c_sel = 3'd0;
    logic [6:0] c_seg;
    logic [0:0] c_dig;
    logic [2:0] c_anim;
    logic [3:0] c_frame;
    logic c_tick, c_done;

    seg_anim_sequencer #(.NUM_DIGITS(1), .DIV_WIDTH(24), .DEFAULT_DIV(3), .SCAN_DIV(1)) dut_a (
        .clk(clk), .reset(a_rst), .div_sel(a_div), .mode(a_mode), .anim_sel(a_sel), .step(a_step),
        .pause(a_pause), .phase_en(a_ph), .seg_out(a_seg), .digit_en(a_dig), .anim_id(a_anim),
        .frame(a_frame), .tick(a_tick), .seq_done(a_done));

    seg_anim_sequencer #(.NUM_DIGITS(4), .DIV_WIDTH(24), .DEFAULT_DIV(3), .SCAN_DIV(2)) dut_b (
        .clk(clk), .reset(b_rst), .div_sel(b_div), .mode(b_mode), .anim_sel(b_sel), .step(b_step),
        .pause(b_pause), .phase_en(b_ph), .seg_out(b_seg), .digit_en(b_dig), .anim_id(b_anim),
        .frame(b_frame), .tick(b_tick), .seq_done(b_done));

    seg_anim_sequencer #(.NUM_DIGITS(1), .DIV_WIDTH(24), .DEFAULT_DIV(3000), .SCAN_DIV(1)) dut_c (
        .clk(clk), .reset(c_rst), .div_sel(c_div), .mode(c_mode), .anim_sel(c_sel), .step(c_step),
        .pause(c_pause), .phase_en(c_ph), .seg_out(c_seg), .digit_en(c_dig), .anim_id(c_anim),
        .frame(c_frame), .tick(c_tick), .seq_done(c_done));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int c = 0;
            do begin
                @(negedge clk);
                c++;
                if (a_done) dcnt++;
            end while (!a_tick && c < 50);
            chk("tick_seen", a_tick, 1);
        end
        @(negedge clk);
        if (a_done) dcnt++;
    endtask

    initial begin
        logic [6:0] ring [6];
        logic [6:0] phs [4];
        int c;
        ring = '{7'h01, 7'h02, 7'h40, 7'h10, 7'h08, 7'h04};
        phs = '{7'h20, 7'h40, 7'h01, 7'h02};

        repeat (2) @(negedge clk);
        chk("rst_seg", a_seg, 0);
        chk("rst_dig", a_dig, 0);
        chk("rst_anim", a_anim, 0);
        chk("rst_tick", a_tick, 0);
        a_rst = 1'b0;
        @(negedge clk);
        chk("first_dig", a_dig, 1);
        chk("first_seg", a_seg, 7'h3F);

        adv_ticks(3);
        chk("t1_frame3", a_frame, 3);
        @(negedge clk);
        chk("t1_seg4f", a_seg, 7'h4F);
        adv_ticks(7);
        chk("t1_anim1", a_anim, 1);
        chk("t1_frame0", a_frame, 0);

        dcnt = 0;
        adv_ticks(33);
        chk("t2_done_pulse", a_done, 1);
        chk("t2_done_count", dcnt, 1);
        chk("t2_anim0", a_anim, 0);
        chk("t2_frame0", a_frame, 0);

        dcnt = 0;
        a_mode = 2'b01;
        a_sel = 3'd0;
        adv_ticks(2);
        chk("t3_frame2", a_frame, 2);
        a_sel = 3'd4;
        @(negedge clk);
        chk("t3_retarget_anim", a_anim, 4);
        chk("t3_retarget_frame", a_frame, 0);
        @(negedge clk);
        chk("t3_ring0", a_seg, ring[0]);
        for (int i = 1; i < 6; i++) begin
            adv_ticks(1);
            @(negedge clk);
            chk("t3_ring", a_seg, ring[i]);
        end
        adv_ticks(1);
        chk("t3_hold_anim", a_anim, 4);
        chk("t3_hold_wrap", a_frame, 0);
        chk("t3_no_done", dcnt, 0);
        a_sel = 3'd7;
        @(negedge clk);
        chk("t3_sel7_anim", a_anim, 0);
        chk("t3_sel7_frame", a_frame, 0);

        a_mode = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a_step = 1'b1;
            @(negedge clk);
            a_step = 1'b0;
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        chk("t4_frame3", a_frame, 3);
        chk("t4_anim0", a_anim, 0);
        a_pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_step = 1'b1;
            @(negedge clk);
            a_step = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("t4_pause_frame", a_frame, 3);
        chk("t4_pause_dig", a_dig, 1);

        b_rst = 1'b0;
        repeat (2) @(negedge clk);
        b_step = 1'b1;
        repeat (15) @(negedge clk);
        b_step = 1'b0;
        b_pause = 1'b1;
        @(negedge clk);
        chk("t5_anim1", b_anim, 1);
        chk("t5_frame5", b_frame, 5);
        c = 0;
        while (b_dig !== 4'b1000 && c < 20) begin @(negedge clk); c++; end
        chk("t5_find_last", b_dig, 4'b1000);
        c = 0;
        while (b_dig !== 4'b0001 && c < 20) begin @(negedge clk); c++; end
        for (int i = 0; i < 8; i++) begin
            chk("t5_dig", b_dig, 32'(1 << (i / 2)));
            chk("t5_seg", b_seg, phs[i/2]);
            @(negedge clk);
        end

        c_rst = 1'b0;
        repeat (2000) @(negedge clk);
        chk("t6_no_tick", c_tick, 0);
        c_div = 8'd1;
        @(negedge clk);
        chk("t6_tick_now", c_tick, 1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!c_tick && c < 2000);
        chk("t6_period", c, 1025);
        chk("t6_frame1", c_frame, 1);
        @(negedge clk);
        chk("t6_frame2", c_frame, 2);
        #2 c_rst = 1'b1;
        #1;
        chk("t6_rst_seg", c_seg, 0);
        chk("t6_rst_dig", c_dig, 0);
        chk("t6_rst_anim", c_anim, 0);
        chk("t6_rst_frame", c_frame, 0);
        chk("t6_rst_tick", c_tick, 0);
        chk("t6_rst_done", c_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
